// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC constants and the per-VC wormhole arbiter state type.
package noc_pkg;
    localparam int VCHANNEL_NUM = 2;
    localparam int NOC_FLIT_WIDTH = 256;
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/noc_rr_lock_arbiter.sv
// noc_rr_lock_arbiter: round-robin grant over INPUTS requesters, held until the tail flit transfers.
module noc_rr_lock_arbiter
    import noc_pkg::*;
#(
    parameter int INPUTS = 5,
    localparam int IW = INPUTS > 1 ? $clog2(INPUTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INPUTS-1:0] valid,
    input  logic [INPUTS-1:0] last,
    input  logic              fire,
    output logic              grant_valid,
    output logic [IW-1:0]     grant_idx
);
    arb_state_e state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt, lock_idx, lock_nxt, rr_idx, cand;
    logic rr_found;

    // Descending scan so the candidate closest to ptr is the one left standing.
    always_comb begin
        rr_idx = '0;
        rr_found = 1'b0;
        cand = '0;
        for (int k = INPUTS - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % INPUTS);
            if (valid[cand]) begin
                rr_idx = cand;
                rr_found = 1'b1;
            end
        end
    end

    assign grant_idx = state == ARB_LOCKED ? lock_idx : rr_idx;
    assign grant_valid = state == ARB_LOCKED ? valid[lock_idx] : rr_found;

    always_comb begin
        state_nxt = state;
        ptr_nxt = ptr;
        lock_nxt = lock_idx;
        if (fire) begin
            state_nxt = last[grant_idx] ? ARB_IDLE : ARB_LOCKED;
            lock_nxt = last[grant_idx] ? lock_idx : grant_idx;
            ptr_nxt = !last[grant_idx] ? ptr : grant_idx == IW'(INPUTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            ptr <= '0;
            lock_idx <= '0;
        end else begin
            state <= state_nxt;
            ptr <= ptr_nxt;
            lock_idx <= lock_nxt;
        end
    end
endmodule

// File: rtl/noc_router_output_arb.sv
// noc_router_output_arb: two-VC wormhole output arbiter sharing one physical link, zero latency.
// Define NOC_ARB_VC0_PRIORITY_EN for strict VC0 priority instead of flit-level VC alternation.
module noc_router_output_arb
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
    parameter int INPUTS = 5
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [1:0][INPUTS-1:0]                 in_valid,
    input  logic [1:0][INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
    input  logic [1:0][INPUTS-1:0]                 in_last,
    output logic [1:0][INPUTS-1:0]                 in_ready,
    output logic [1:0]                             out_valid,
    output logic [FLIT_WIDTH-1:0]                  out_flit,
    output logic                                   out_last,
    input  logic [1:0]                             out_ready
);
    localparam int IW = INPUTS > 1 ? $clog2(INPUTS) : 1;
    logic [VCHANNEL_NUM-1:0] grant_valid, elig;
    logic [VCHANNEL_NUM-1:0][IW-1:0] grant_idx;
    logic sel;

    for (genvar v = 0; v < VCHANNEL_NUM; v++) begin : g_vc
        noc_rr_lock_arbiter #(.INPUTS(INPUTS)) u_arb (
            .clk(clk),
            .rst_n(rst_n),
            .valid(in_valid[v]),
            .last(in_last[v]),
            .fire(out_valid[v]),
            .grant_valid(grant_valid[v]),
            .grant_idx(grant_idx[v])
        );
    end

    // Gated by rst_n so nothing is offered on the link while reset is held.
    assign elig = grant_valid & out_ready & {VCHANNEL_NUM{rst_n}};

`ifdef NOC_ARB_VC0_PRIORITY_EN
    assign sel = ~elig[0];
`else
    logic last_vc;
    assign sel = &elig ? ~last_vc : elig[1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_vc <= 1'b1;
        else if (|out_valid) last_vc <= sel;
    end
`endif

    assign out_valid = elig & {sel, ~sel};
    assign out_flit = |out_valid ? in_flit[sel][grant_idx[sel]] : '0;
    assign out_last = |out_valid & in_last[sel][grant_idx[sel]];

    always_comb begin
        in_ready = '0;
        for (int v = 0; v < VCHANNEL_NUM; v++)
            for (int i = 0; i < INPUTS; i++)
                in_ready[v][i] = out_valid[v] && grant_idx[v] == IW'(i);
    end
endmodule

// File: tb/tb_noc_router_output_arb.sv
// tb_noc_router_output_arb: scoreboard bench with directed wormhole scenarios and a randomized phase.
module tb_noc_router_output_arb;
    localparam int N = 5;
    localparam int FW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0][N-1:0] in_valid, in_last, in_ready;
    logic [1:0][N-1:0][FW-1:0] in_flit;
    logic [1:0] out_valid, out_ready;
    logic [FW-1:0] out_flit;
    logic out_last;

    always #5 clk = ~clk;

    noc_router_output_arb #(.FLIT_WIDTH(FW), .INPUTS(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_flit(out_flit), .out_last(out_last),
        .out_ready(out_ready)
    );

    typedef struct packed {
        logic [1:0] ov;
        logic [FW-1:0] fl;
        logic la;
        logic [1:0][N-1:0] rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int link_log[$];
    int checks = 0;
    int failures = 0;
    int rem[2][N], hold[2][N], pkt_id[2][N], fidx[2][N];
    bit bubbles = 0;
    int owner[2], ptr[2], last_vc;

    // Reference model: per VC the input that owns the wormhole (-1 = none) and next-priority input.
    function automatic void model_reset();
        owner = '{-1, -1};
        ptr = '{0, 0};
        last_vc = 1;
    endfunction

    function automatic void pkt(int v, int i, int len);
        rem[v][i] = len;
    endfunction

    function automatic bit busy();
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < N; i++)
                if (rem[v][i] > 0) return 1;
        return 0;
    endfunction

    task automatic cycle();
        exp_t e;
        int gi[2];
        logic [1:0] gv, elig;
        int sel;
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < N; i++) begin
                in_valid[v][i] = rem[v][i] > 0 && hold[v][i] == 0 && !(bubbles && $urandom_range(3) == 0);
                in_last[v][i] = rem[v][i] == 1;
                in_flit[v][i] = {4'(v), 4'(i), 16'(pkt_id[v][i]), 8'(fidx[v][i])};
                if (hold[v][i] > 0) hold[v][i]--;
            end
        e = '0;
        for (int v = 0; v < 2; v++) begin
            gi[v] = owner[v];
            if (owner[v] < 0)
                for (int k = N - 1; k >= 0; k--)
                    if (in_valid[v][(ptr[v] + k) % N]) gi[v] = (ptr[v] + k) % N;
            gv[v] = gi[v] >= 0 ? in_valid[v][gi[v]] : 1'b0;
        end
        elig = gv & out_ready & {2{rst_n}};
`ifdef NOC_ARB_VC0_PRIORITY_EN
        sel = elig[0] ? 0 : 1;
`else
        sel = elig == 2'b11 ? 1 - last_vc : (elig[1] ? 1 : 0);
`endif
        if (elig != 0) begin
            e.ov[sel] = 1'b1;
            e.fl = in_flit[sel][gi[sel]];
            e.la = in_last[sel][gi[sel]];
            e.rdy[sel][gi[sel]] = 1'b1;
            last_vc = sel;
            if (in_last[sel][gi[sel]]) begin
                owner[sel] = -1;
                ptr[sel] = (gi[sel] + 1) % N;
                pkt_id[sel][gi[sel]]++;
                fidx[sel][gi[sel]] = 0;
            end else begin
                owner[sel] = gi[sel];
                fidx[sel][gi[sel]]++;
            end
            rem[sel][gi[sel]]--;
        end
        if (!rst_n) model_reset();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string nm);
        int n = 0;
        while ((busy() || exp_q.size() > 0) && n < 300) begin
            cycle();
            n++;
        end
        checks++;
        if (busy()) begin
            failures++;
            $display("FAIL drain_%s: packets still pending after %0d cycles, required none", nm, n);
        end
    endtask

    task automatic check_log(string nm, logic [63:0] expv);
        logic [63:0] got = 64'hF;
        foreach (link_log[k]) got = (got << 4) | 64'(link_log[k]);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL order_%s: link sources got=%h required=%h", nm, got, expv);
        end
        link_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < N; i++) rem[v][i] = 0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({out_valid, out_flit, out_last, in_ready} !== mon_e) begin
                failures++;
                $display("FAIL link: got ov=%b flit=%h last=%b rdy=%b required ov=%b flit=%h last=%b rdy=%b",
                         out_valid, out_flit, out_last, in_ready, mon_e.ov, mon_e.fl, mon_e.la, mon_e.rdy);
            end
        end else if (out_valid != 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected: got ov=%b required no transfer", out_valid);
        end
        if (out_valid != 0) link_log.push_back(out_valid[1] ? 8 + int'(out_flit[27:24]) : int'(out_flit[27:24]));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        in_valid = '0;
        in_last = '0;
        in_flit = '0;
        out_ready = 2'b11;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        link_log.delete();
        pkt(0, 1, 3);
        pkt(0, 3, 3);
        drain("rr");
        check_log("rr_contiguous", 64'hF111333);
        pkt(0, 0, 1);
        pkt(0, 4, 1);
        drain("ptr4");
        check_log("ptr_after_3", 64'hF40);
        pkt(1, 4, 1);
        cycle();
        drain("single");
        check_log("single_flit", 64'hFC);
        pkt(1, 0, 1);
        pkt(1, 4, 1);
        drain("wrap");
        check_log("ptr_wrap", 64'hF8C);
        pkt(0, 2, 4);
        cycle();
        hold[0][2] = 2;
        pkt(0, 0, 1);
        drain("bubble");
        check_log("bubble_lock", 64'hF22220);
        pkt(1, 1, 3);
        cycle();
        out_ready = 2'b01;
        pkt(0, 2, 3);
        pkt(1, 0, 1);
        repeat (4) cycle();
        out_ready = 2'b11;
        drain("stall");
        check_log("vc1_stall", 64'hF9222998);
        do_reset();
        link_log.delete();
        pkt(0, 0, 6);
        pkt(1, 0, 6);
        repeat (6) cycle();
`ifdef NOC_ARB_VC0_PRIORITY_EN
        check_log("vc_prio", 64'hF000000);
`else
        check_log("vc_alt", 64'hF080808);
`endif
        drain("alt");
        link_log.delete();
        pkt(0, 3, 4);
        repeat (2) cycle();
        pkt(0, 3, 2);
        pkt(0, 1, 1);
        rst_n = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < N; i++) rem[0][i] = 0;
        rst_n = 1'b1;
        pkt(0, 4, 1);
        pkt(0, 1, 1);
        drain("reset");
        check_log("reset_mid_pkt", 64'hF3314);
        bubbles = 1;
        for (int c = 0; c < 1500; c++) begin
            out_ready = 2'($urandom);
            rst_n = $urandom_range(299) != 0;
            for (int v = 0; v < 2; v++)
                for (int i = 0; i < N; i++)
                    if (rem[v][i] == 0 && $urandom_range(7) == 0) rem[v][i] = $urandom_range(1, 4);
            cycle();
        end
        rst_n = 1'b1;
        bubbles = 0;
        out_ready = 2'b11;
        drain("random");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
